// File: rtl/alu_share_if.sv
// alu_share_if: request/response bundle between the two ALU requesters,
// the shared-ALU arbiter and the result consumer.
//   req0_*  : execute-stage requester (valid/ready, operands, op, set_cc)
//   req1_*  : auxiliary requester (valid/ready, operands, op)
//   rsp_*   : registered result with valid/ready handshake and owner id
// master modport: requester/consumer side. slave modport: arbiter side.
interface alu_share_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [63:0] req0_a;
   logic [63:0] req0_b;
   logic [1:0]  req0_op;
   logic        req0_set_cc;

   logic        req1_valid;
   logic        req1_ready;
   logic [63:0] req1_a;
   logic [63:0] req1_b;
   logic [1:0]  req1_op;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [63:0] rsp_result;
   logic        rsp_overflow;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_set_cc,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_overflow
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_set_cc,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_overflow
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of the 64-bit execute ALU
// (op 00 add, 01 sub, 10 and, 11 xor) between two requesters, with
// registered operands and a registered valid/ready result.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : requester 0/1 handshakes and the response channel
//   cc_zf/sf/of   : architectural condition codes
//   perf_busy     : saturating count of cycles spent in EXEC or RESP
// Build option: define ALU_SHARE_CC_EN to include the condition-code
// register; without it cc_* are tied low and req0_set_cc is ignored.
//
// state | meaning
// IDLE  | waiting for a request; ready driven for the granted requester
// EXEC  | ALU evaluates latched operands; result captured at exit
// RESP  | result held on rsp_* until the consumer takes it
module alu_share_arbiter #(
   parameter int PERF_W      = 16,
   parameter bit CC_RESET_ZF = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_if.slave        bus,
   output logic              cc_zf,
   output logic              cc_sf,
   output logic              cc_of,
   output logic [PERF_W-1:0] perf_busy
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [PERF_W-1:0] PERF_ONE = 1;

   state_t      state, state_nxt;
   logic        accept;
   logic        gnt_id;
   logic        last_grant;
   logic [63:0] a_q, b_q;
   logic [1:0]  op_q;
   logic        id_q;
   logic [63:0] alu_res;
   logic        alu_ovf;
   logic        rsp_valid_q, rsp_id_q, rsp_ovf_q;
   logic [63:0] rsp_result_q;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      gnt_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         gnt_id = ~last_grant;
      else if (bus.req1_valid)
         gnt_id = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               accept    = 1'b1;
               state_nxt = S_EXEC;
            end
         end
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.req0_ready = accept & ~gnt_id;
   assign bus.req1_ready = accept &  gnt_id;

   // Signed overflow: operands of matching (add) / differing (sub) sign
   // producing a result whose sign differs from operand A.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op_q)
         2'b00: begin
            alu_res = a_q + b_q;
            alu_ovf = (a_q[63] == b_q[63]) && (alu_res[63] != a_q[63]);
         end
         2'b01: begin
            alu_res = a_q - b_q;
            alu_ovf = (a_q[63] != b_q[63]) && (alu_res[63] != a_q[63]);
         end
         2'b10:   alu_res = a_q & b_q;
         default: alu_res = a_q ^ b_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         last_grant   <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= 2'b00;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_ovf_q    <= 1'b0;
         perf_busy    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_q        <= gnt_id ? bus.req1_a  : bus.req0_a;
            b_q        <= gnt_id ? bus.req1_b  : bus.req0_b;
            op_q       <= gnt_id ? bus.req1_op : bus.req0_op;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
         end
         if (state == S_EXEC) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= alu_res;
            rsp_ovf_q    <= alu_ovf;
         end else if (state == S_RESP && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         if (state != S_IDLE && perf_busy != '1)
            perf_busy <= perf_busy + PERF_ONE;
      end
   end

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_overflow = rsp_ovf_q;

`ifdef ALU_SHARE_CC_EN
   logic set_cc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         set_cc_q <= 1'b0;
         cc_zf    <= CC_RESET_ZF;
         cc_sf    <= 1'b0;
         cc_of    <= 1'b0;
      end else begin
         if (accept)
            set_cc_q <= ~gnt_id & bus.req0_set_cc;
         if (state == S_EXEC && set_cc_q) begin
            cc_zf <= (alu_res == 64'd0);
            cc_sf <= alu_res[63];
            cc_of <= alu_ovf;
         end
      end
   end
`else
   localparam bit unused_cc_reset_zf = CC_RESET_ZF;
   logic unused_set_cc;
   assign unused_set_cc = bus.req0_set_cc;
   assign cc_zf = 1'b0;
   assign cc_sf = 1'b0;
   assign cc_of = 1'b0;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
`ifdef ALU_SHARE_CC_EN
   localparam bit CC_EN = 1'b1;
`else
   localparam bit CC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cc_zf, cc_sf, cc_of;
   logic [15:0] perf_busy;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_share_if bus();

   alu_share_arbiter #(.PERF_W(16), .CC_RESET_ZF(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cc_zf     (cc_zf),
      .cc_sf     (cc_sf),
      .cc_of     (cc_of),
      .perf_busy (perf_busy)
   );

   typedef struct {
      logic        id;
      logic [63:0] res;
      logic        ovf;
      logic        set_cc;
   } exp_t;

   typedef struct {
      logic        id;
      logic [63:0] a;
      logic [63:0] b;
      logic [1:0]  op;
      logic        set_cc;
      logic [63:0] exp_res;
      logic        exp_ovf;
   } vec_t;

   exp_t sb[$];
   int   grant_log[$];
   int   grant_cyc[$];
   logic m_zf, m_sf, m_of;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void alu_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [1:0] op,
                                     output logic [63:0] r, output logic o);
      logic [64:0] w;
      w = '0;
      o = 1'b0;
      case (op)
         2'b00: begin w = {a[63], a} + {b[63], b}; r = w[63:0]; o = w[64] ^ w[63]; end
         2'b01: begin w = {a[63], a} - {b[63], b}; r = w[63:0]; o = w[64] ^ w[63]; end
         2'b10: r = a & b;
         default: r = a ^ b;
      endcase
   endfunction

   // Scoreboard: push on accept, pop and compare on response handshake.
   always @(negedge clk) begin
      exp_t e;
      logic [63:0] r;
      logic o;
      if (!rst) begin
         chk("one_ready", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
         if (bus.req0_ready) begin
            chk("r0_ready_needs_valid", {63'd0, bus.req0_valid}, 64'd1);
            alu_model(bus.req0_a, bus.req0_b, bus.req0_op, r, o);
            e.id = 1'b0; e.res = r; e.ovf = o; e.set_cc = bus.req0_set_cc;
            sb.push_back(e);
            grant_log.push_back(0);
            grant_cyc.push_back(cyc);
         end
         if (bus.req1_ready) begin
            chk("r1_ready_needs_valid", {63'd0, bus.req1_valid}, 64'd1);
            alu_model(bus.req1_a, bus.req1_b, bus.req1_op, r, o);
            e.id = 1'b1; e.res = r; e.ovf = o; e.set_cc = 1'b0;
            sb.push_back(e);
            grant_log.push_back(1);
            grant_cyc.push_back(cyc);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual=%h required=none", bus.rsp_result);
            end else begin
               e = sb.pop_front();
               chk("sb_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
               chk("sb_result", bus.rsp_result, e.res);
               chk("sb_overflow", {63'd0, bus.rsp_overflow}, {63'd0, e.ovf});
               if (CC_EN && e.set_cc) begin
                  m_zf = (e.res == 64'd0);
                  m_sf = e.res[63];
                  m_of = e.ovf;
               end
               chk("cc_zf", {63'd0, cc_zf}, {63'd0, m_zf});
               chk("cc_sf", {63'd0, cc_sf}, {63'd0, m_sf});
               chk("cc_of", {63'd0, cc_of}, {63'd0, m_of});
            end
         end
      end
   end

   task automatic drive_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] op, input logic set_cc);
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
         bus.req0_set_cc = set_cc;
      end
   endtask

   task automatic reset_cc_model();
      m_zf = CC_EN;
      m_sf = 1'b0;
      m_of = 1'b0;
   endtask

   vec_t vecs[11];
   int   p0;
   int   n;

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1, 64'h8000_0000_0000_0000, 1};
      vecs[1]  = '{1, 64'hF0F0, 64'h0FF0, 2'b10, 0, 64'h00F0, 0};
      vecs[2]  = '{0, 64'd5, 64'd5, 2'b01, 1, 64'd0, 0};
      vecs[3]  = '{1, 64'hF0F0, 64'h0FF0, 2'b11, 0, 64'hFF00, 0};
      vecs[4]  = '{0, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1};
      vecs[5]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1, 64'd0, 0};
      vecs[6]  = '{1, 64'd0, 64'd1, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[7]  = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1, 64'h8000_0000_0000_0000, 0};
      vecs[8]  = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 0, 64'd0, 1};
      vecs[9]  = '{0, 64'h1234, 64'h1234, 2'b11, 1, 64'd0, 0};
      vecs[10] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01, 1, 64'h8000_0000_0000_0000, 0};

      rst = 1'b1;
      bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0; bus.req0_set_cc = 0;
      bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
      bus.rsp_ready = 0;
      reset_cc_model();

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("rst_rsp_result", bus.rsp_result, 64'd0);
      chk("rst_cc_zf", {63'd0, cc_zf}, {63'd0, CC_EN});
      chk("rst_cc_sf", {63'd0, cc_sf}, 64'd0);
      chk("rst_cc_of", {63'd0, cc_of}, 64'd0);
      chk("rst_perf", {48'd0, perf_busy}, 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);

      // Table-driven single operations with exact latency
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].set_cc);
         @(negedge clk);
         chk("accept", {63'd0, vecs[i].id ? bus.req1_ready : bus.req0_ready}, 64'd1);
         @(posedge clk); #1;
         bus.req0_valid = 0; bus.req1_valid = 0;
         @(negedge clk);
         chk("exec_no_valid", {63'd0, bus.rsp_valid}, 64'd0);
         @(negedge clk);
         chk("vec_valid", {63'd0, bus.rsp_valid}, 64'd1);
         chk("vec_result", bus.rsp_result, vecs[i].exp_res);
         chk("vec_overflow", {63'd0, bus.rsp_overflow}, {63'd0, vecs[i].exp_ovf});
         chk("vec_id", {63'd0, bus.rsp_id}, {63'd0, vecs[i].id});
         @(posedge clk); #1 bus.rsp_ready = 1;
         @(posedge clk); #1 bus.rsp_ready = 0;
      end

      // Backpressure: result held for 11 RESP cycles, requests ignored
      @(posedge clk); #1;
      drive_req(1, 64'hF0F0, 64'h0FF0, 2'b11, 0);
      @(negedge clk);
      chk("bp_accept", {63'd0, bus.req1_ready}, 64'd1);
      p0 = int'(perf_busy);
      @(posedge clk); #1;
      drive_req(0, 64'd9, 64'd9, 2'b00, 1);
      @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
         chk("bp_result", bus.rsp_result, 64'hFF00);
         chk("bp_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      end
      chk("bp_perf", {48'd0, perf_busy}, 64'(p0 + 11));
      @(posedge clk); #1;
      bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
      @(posedge clk); #1 bus.rsp_ready = 0;

      // Reset while in EXEC: no response, registers back to reset values
      @(posedge clk); #1;
      drive_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1);
      @(negedge clk);
      chk("mid_accept", {63'd0, bus.req0_ready}, 64'd1);
      @(posedge clk); #1;
      rst = 1'b1; bus.req0_valid = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete(); grant_log.delete(); grant_cyc.delete();
      reset_cc_model();
      @(negedge clk);
      chk("mid_perf", {48'd0, perf_busy}, 64'd0);
      chk("mid_cc_zf", {63'd0, cc_zf}, {63'd0, CC_EN});
      chk("mid_cc_sf", {63'd0, cc_sf}, 64'd0);
      chk("mid_cc_of", {63'd0, cc_of}, 64'd0);
      for (int k = 0; k < 4; k++) begin
         chk("mid_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
         @(negedge clk);
      end

      // Tie arbitration with continuous rsp_ready
      @(posedge clk); #1;
      drive_req(0, 64'd1, 64'd2, 2'b00, 1);
      drive_req(1, 64'd5, 64'd5, 2'b01, 0);
      bus.rsp_ready = 1;
      n = 0;
      while (grant_log.size() < 6 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      bus.req0_valid = 0; bus.req1_valid = 0;
      if (grant_log.size() < 6) begin
         checks++; errors++;
         $display("FAIL tie_timeout actual=%0d required=6", grant_log.size());
      end else begin
         for (int i = 0; i < 6; i++)
            chk("tie_order", 64'(grant_log[i]), 64'(i % 2));
         for (int i = 1; i < 6; i++)
            chk("tie_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd3);
      end
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1 bus.rsp_ready = 0;
      chk("drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 64-bit execute-stage ALU (control 00 add, 01 sub, 10 and, 11 xor; overflow reported for add/sub only) between two requesters.
- Requester 0 is the execute stage (OPq / address arithmetic); requester 1 is an auxiliary datapath user.
- Round-robin arbitration, registered operands, registered result with valid/ready output handshake.
- Owns the architectural condition-code register when enabled.

Parameters:
- PERF_W, 16, width of the saturating busy-cycle counter.
- CC_RESET_ZF, 1, reset value of cc_zf.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  64  operand A
- req0_b  in  64  operand B
- req0_op  in  2  ALU control code
- req0_set_cc  in  1  update condition codes from this result
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  64  operand A
- req1_b  in  64  operand B
- req1_op  in  2  ALU control code
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_result  out  64  ALU result
- rsp_overflow  out  1  ALU overflow flag
- cc_zf  out  1  zero flag
- cc_sf  out  1  sign flag
- cc_of  out  1  overflow flag
- perf_busy  out  PERF_W  cycles spent in EXEC or RESP, saturating

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0
  - cc_zf=CC_RESET_ZF, cc_sf=0, cc_of=0
  - perf_busy=0, last_grant=1 (so requester 0 wins the first tie)
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, only for the granted requester, which must have valid=1. At most one ready is high per cycle.
  - Grant rule: only one valid → grant it. Both valid → grant the requester that is not last_grant.
  - On grant: latch a, b, op, id, and set_cc (forced 0 for requester 1); update last_grant; go to EXEC.
  - No valid → stay in IDLE; ready outputs are 0.
- EXEC (exactly 1 cycle):
  - The ALU sees the latched operands.
  - At the clock edge: capture result and overflow into the rsp registers, set rsp_valid=1, go to RESP.
  - Overflow is 0 for op 10 and op 11.
  - Subtraction is the ALU's A minus B. 64-bit two's-complement wrap; no saturation.
- RESP:
  - rsp_valid=1; all rsp_* outputs are stable until the handshake.
  - rsp_valid & rsp_ready → rsp_valid=0 next cycle, go to IDLE.
  - No new request is accepted in the handshake cycle, so minimum spacing is 3 cycles per operation.
- Latency: accept at edge N → rsp_valid high after edge N+1.
- Condition codes (CC_EN build): updated at the EXEC→RESP edge only when the latched set_cc=1.
  - cc_zf = (result==0)
  - cc_sf = result[63]
  - cc_of = overflow
  - Otherwise the codes hold their value.
- perf_busy: +1 every cycle the FSM is in EXEC or RESP; holds at all-ones.
- Boundaries:
  - A request dropping valid while not granted is legal; nothing is recorded.
  - Requester inputs are ignored outside IDLE.
  - rst in any state takes priority: FSM→IDLE, any in-flight result is discarded (no response), all registers return to reset values the next cycle.
  - A rsp_ready held high continuously gives back-to-back operations every 3 cycles.

Optional Feature:
- Macro ALU_SHARE_CC_EN.
- Defined: the condition-code register and its update logic are present as described.
- Undefined: no CC flops; cc_zf, cc_sf, cc_of are tied to 0 and req0_set_cc is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → rsp_valid=0, cc_zf=1, cc_sf=0, cc_of=0, perf_busy=0; no ready high.
- Add with overflow: req0 a=0x7FFFFFFFFFFFFFFF, b=1, op=00, set_cc=1 → accepted same cycle. Two cycles later rsp_result=0x8000000000000000, rsp_overflow=1, rsp_id=0, cc_sf=1, cc_of=1, cc_zf=0.
- Tie arbitration: both valid every cycle, rsp_ready=1.
  - Grants alternate 0,1,0,1, one grant every 3 cycles.
  - req1 op=01 with a=5, b=5 → result 0 with CC unchanged.
- Backpressure: rsp_ready=0 for 10 cycles after req1 op=11 with a=0xF0F0, b=0x0FF0.
  - rsp_result holds 0xFF00 and rsp_valid holds 1 throughout; both readies stay 0.
  - perf_busy increases by 11.
- Reset mid-operation: assert rst in EXEC → no rsp_valid pulse; CC returns to reset values; next request is served normally.
- CC_EN off build: repeat the add-with-overflow scenario → identical rsp outputs; cc_* remain 0.
